// File: rtl/pipeline_pkg.sv
// Shared RV64I pipeline types: stage payloads, funct3 load/store size codes and MEM FSM states.
package pipeline_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned RF_SIZE    = 5;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_D  = 3'b011;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;
  localparam logic [2:0] FUNCT3_WU = 3'b110;

  typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_WAIT} mem_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] PC;
    logic [DATA_WIDTH-1:0] PC_Next;
    logic [DATA_WIDTH-1:0] ALU_Result;
    logic [DATA_WIDTH-1:0] Store_Data;
    logic [RF_SIZE-1:0]    RD_Addr;
    logic                  Reg_WEn;
    logic                  Mem_REn;
    logic                  Mem_WEn;
    logic [2:0]            Detail;
  } EXMEM_Pipe_Out_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] PC;
    logic [DATA_WIDTH-1:0] PC_Next;
    logic [DATA_WIDTH-1:0] WB_Data;
    logic [RF_SIZE-1:0]    RD_Addr;
    logic                  Reg_WEn;
  } MEMWB_Pipe_t;

  // Unshifted byte-lane mask for an access size; the reserved code 111 touches no lanes.
  function automatic logic [7:0] size_mask(input logic [2:0] detail);
    logic [7:0] m;
    case (detail[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    if (detail == 3'b111) m = 8'h00;
    return m;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data formatter: shifts the addressed bytes down and sign/zero-extends to 64 bits.
module mem_load_align
  import pipeline_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [2:0]            i_off,
  input  logic [2:0]            i_detail,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] w_sh;

  assign w_sh = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_data = '0;
    case (i_detail)
      FUNCT3_B:  o_data = {{56{w_sh[7]}},  w_sh[7:0]};
      FUNCT3_H:  o_data = {{48{w_sh[15]}}, w_sh[15:0]};
      FUNCT3_W:  o_data = {{32{w_sh[31]}}, w_sh[31:0]};
      FUNCT3_D:  o_data = w_sh;
      FUNCT3_BU: o_data = {56'b0, w_sh[7:0]};
      FUNCT3_HU: o_data = {48'b0, w_sh[15:0]};
      FUNCT3_WU: o_data = {32'b0, w_sh[31:0]};
      default:   o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV64I MEM stage: one data-memory access per packet over req/gnt/rvalid, result held for WB.
// Optional MEM_STAGE_MISALIGN_CHECK_EN suppresses misaligned accesses and adds the misalign pulse.
module mem_stage
  import pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  EXMEM_Pipe_Out_t       in_pipe,
  output logic                  out_valid,
  input  logic                  out_ready,
  output MEMWB_Pipe_t           out_pipe,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [7:0]            dmem_wmask,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  ,
  output logic                  misalign
`endif
);

  mem_state_t            r_state;
  MEMWB_Pipe_t           r_pend;
  logic [2:0]            r_off;
  logic [2:0]            r_detail;

  logic                  w_accept;
  logic                  w_is_mem;
  logic                  w_misalign;
  logic [2:0]            w_off;
  MEMWB_Pipe_t           w_pend;
  logic [DATA_WIDTH-1:0] w_load_data;

  assign w_off    = in_pipe.ALU_Result[2:0];
  assign w_is_mem = in_pipe.Mem_REn || in_pipe.Mem_WEn;
  assign in_ready = !rst && (r_state == MEM_IDLE) && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  assign w_pend = '{PC:      in_pipe.PC,
                    PC_Next: in_pipe.PC_Next,
                    WB_Data: in_pipe.ALU_Result,
                    RD_Addr: in_pipe.RD_Addr,
                    Reg_WEn: in_pipe.Reg_WEn};

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  // Offset must be a multiple of the access size.
  always_comb begin
    w_misalign = 1'b0;
    if (w_is_mem && (in_pipe.Detail != 3'b111)) begin
      case (in_pipe.Detail[1:0])
        2'b01:   w_misalign = w_off[0];
        2'b10:   w_misalign = |w_off[1:0];
        2'b11:   w_misalign = |w_off;
        default: w_misalign = 1'b0;
      endcase
    end
  end
`else
  assign w_misalign = 1'b0;
`endif

  mem_load_align u_load_align (
    .i_rdata  (dmem_rdata),
    .i_off    (r_off),
    .i_detail (r_detail),
    .o_data   (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= MEM_IDLE;
      r_pend     <= '0;
      r_off      <= '0;
      r_detail   <= '0;
      out_valid  <= 1'b0;
      out_pipe   <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
      misalign   <= 1'b0;
`endif
    end else begin
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
      misalign <= 1'b0;
`endif
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (r_state)
        MEM_IDLE: begin
          if (w_accept) begin
            if (!w_is_mem || w_misalign) begin
              out_pipe         <= w_pend;
              out_pipe.Reg_WEn <= in_pipe.Reg_WEn && !w_misalign;
              out_valid        <= 1'b1;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
              misalign         <= w_misalign;
`endif
            end else begin
              r_pend     <= w_pend;
              r_off      <= w_off;
              r_detail   <= in_pipe.Detail;
              dmem_req   <= 1'b1;
              dmem_we    <= !in_pipe.Mem_REn;
              dmem_addr  <= {in_pipe.ALU_Result[DATA_WIDTH-1:3], 3'b000};
              dmem_wmask <= size_mask(in_pipe.Detail) << w_off;
              dmem_wdata <= in_pipe.Store_Data << {w_off, 3'b000};
              r_state    <= MEM_REQ;
            end
          end
        end
        MEM_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              out_pipe         <= r_pend;
              out_pipe.Reg_WEn <= 1'b0;
              out_valid        <= 1'b1;
              r_state          <= MEM_IDLE;
            end else if (dmem_rvalid) begin
              out_pipe         <= r_pend;
              out_pipe.WB_Data <= w_load_data;
              out_valid        <= 1'b1;
              r_state          <= MEM_IDLE;
            end else begin
              r_state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (dmem_rvalid) begin
            out_pipe         <= r_pend;
            out_pipe.WB_Data <= w_load_data;
            out_valid        <= 1'b1;
            r_state          <= MEM_IDLE;
          end
        end
        default: r_state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV64I pipeline. Consumes an EXMEM_Pipe_Out_t packet over a valid/ready handshake and issues at most one data-memory access per packet.
- The memory access uses a req/gnt/rvalid handshake. The stage aligns store data, builds byte masks, and extracts plus sign/zero-extends load data.
- Results are held in an internal MEMWB register and presented to WB over valid/ready.

Parameters:
- DATA_WIDTH, 64, datapath and memory word width (from pipeline_pkg).
- RF_SIZE, 5, register address width (from pipeline_pkg).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream packet valid.
- in_ready  out  1  stage can accept a packet.
- in_pipe  in  EXMEM_Pipe_Out_t  EX->MEM packet (PC, PC_Next, ALU_Result=address/result, Store_Data, RD_Addr, Reg_WEn, Mem_REn, Mem_WEn, Detail=funct3).
- out_valid  out  1  out_pipe holds a valid result.
- out_ready  in  1  WB consumes out_pipe.
- out_pipe  out  MEMWB_Pipe_t  MEM->WB packet.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  64  doubleword-aligned address: ALU_Result with bits [2:0] = 0.
- dmem_wmask  out  8  byte-lane write enables.
- dmem_wdata  out  64  Store_Data shifted left by addr[2:0]*8.
- dmem_gnt  in  1  request accepted; a store completes on gnt.
- dmem_rvalid  in  1  load data valid; asserted one or more cycles after gnt.
- dmem_rdata  in  64  load doubleword.

Behaviour:
- Reset values: in_ready=0 during rst; out_valid=0; out_pipe='0; dmem_req=0; dmem_we=0; dmem_wmask=0; FSM=IDLE. A reset mid-access drops dmem_req immediately and discards any later rvalid.
- FSM states:
  - IDLE: waiting for a packet.
  - REQ: dmem_req held high with address, mask and data stable until gnt.
  - WAIT: load granted, waiting for rvalid.
- in_ready = (state==IDLE) && (!out_valid || out_ready). An accept and an out_pipe drain in the same cycle are legal.
- Non-memory packet (Mem_REn=0, Mem_WEn=0):
  - Loaded into out_pipe at accept, so out_valid rises the next cycle (1-cycle latency).
  - WB_Data = ALU_Result; Reg_WEn passes through.
- Memory packet:
  - At accept the stage latches the packet and goes to REQ; dmem_req is asserted the following cycle.
  - Mem_REn and Mem_WEn both set: treated as a load.
- Store:
  - REQ&&gnt -> out_pipe loaded (WB_Data=ALU_Result, Reg_WEn forced 0) -> IDLE.
  - Minimum latency is 2 cycles from accept to out_valid.
- Load:
  - REQ&&gnt -> WAIT, with dmem_req deasserted.
  - WAIT&&rvalid -> out_pipe loaded with the formatted data -> IDLE.
  - gnt and rvalid in the same cycle in REQ is legal; it completes directly to IDLE.
- Detail decode:
  - 000 B/SB, 001 H/SH, 010 W/SW, 011 D/SD.
  - 100 BU, 101 HU, 110 WU.
  - 111: no mask, load data = 0.
- Store mask: the size mask (1, 3, 0xF or 0xFF) shifted left by off=addr[2:0], truncated to 8 bits.
- Load extract: dmem_rdata >> (off*8), then the low 8/16/32/64 bits sign- or zero-extended to 64 bits.
- PC, PC_Next and RD_Addr pass through unchanged.
- out_pipe stays stable while out_valid && !out_ready.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_CHECK_EN.
- When defined:
  - Adds output port misalign (1 bit).
  - A memory packet whose off is not a multiple of its size (H: off[0], W: off[1:0], D: off[2:0]) issues no dmem_req.
  - The packet completes as a non-memory packet (1-cycle latency) with Reg_WEn=0.
  - misalign pulses high for one cycle when that out_pipe is loaded.
- When not defined:
  - No misalign port.
  - Misaligned accesses are issued as-is: lanes above byte 7 are dropped from the mask and data, and loads see the shifted, zero-filled high bytes.

Decomposition:
- Additions to pipeline_pkg:
  - Detail constants: FUNCT3_B, FUNCT3_H, FUNCT3_W, FUNCT3_D, FUNCT3_BU, FUNCT3_HU, FUNCT3_WU.
  - typedef enum logic [1:0] mem_state_t {MEM_IDLE, MEM_REQ, MEM_WAIT}.
- One combinational sub-module, mem_load_align: inputs rdata, off and Detail; output extended 64-bit data. Store mask/data generation stays in mem_stage.

Test Plan:
- ALU packet ALU_Result=0x1234, Reg_WEn=1, out_ready=1 -> out_valid one cycle after accept, WB_Data=0x1234, no dmem_req.
- SB at addr 0x1003, Store_Data=0xAB, gnt immediate -> dmem_addr=0x1000, wmask=0x08, wdata[31:24]=0xAB, out Reg_WEn=0.
- LB at 0x2006, rdata=0x0080_0000_0000_0000, rvalid 3 cycles after gnt -> WB_Data=0xFFFF_FFFF_FFFF_FF80. Same access as LBU -> WB_Data=0x80. in_ready=0 throughout.
- LW at 0x0 with gnt delayed 4 cycles and out_ready=0 for 2 cycles after completion:
  - Required: req/addr stable until gnt; out_pipe held stable while stalled; no second accept until drain.
- rst asserted in WAIT, then rvalid arrives -> out_valid stays 0 and state is IDLE; the next LD completes normally.
- (MISALIGN_CHECK_EN) LW at 0x2 -> no dmem_req, misalign pulses 1 cycle, Reg_WEn=0.
